// File: rtl/fetch_controller.sv
// Fetch sequencer: issues imem reads in RUN and queues {pc,instr} in a 2-entry FIFO for decode; PC->out_valid is 1 cycle.
// Issue stalls while the FIFO is full and not popping; redirect flushes. Optional FETCH_BOUNDS_CHECK_EN adds a sticky alignment/range fault.
module fetch_controller #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        imem_ce,
  output logic        imem_read_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  fetch_ent_t  ent0_q, ent0_d;
  fetch_ent_t  ent1_q, ent1_d;
  fetch_ent_t  new_ent;
  logic [1:0]  count_q, count_d;
  logic        fault_q, fault_d;
  logic        pop, can_issue, issue, fault_set, pc_bad;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] PC_LIMIT = 33'(DEPTH_WORDS) * 33'd4;
  assign pc_bad = (fetch_pc_q[1:0] != 2'b00) || ({1'b0, fetch_pc_q} >= PC_LIMIT);
`else
  assign pc_bad = 1'b0;
`endif

  // A redirect kills the head even when decode is ready in the same cycle.
  assign pop       = out_valid && out_ready && !redir_valid;
  assign can_issue = (state_q == ST_RUN) && !redir_valid && ((count_q != 2'd2) || pop);
  assign fault_set = can_issue && pc_bad;
  assign issue     = can_issue && !pc_bad;
  assign new_ent   = '{pc: fetch_pc_q, instr: imem_instr};

  always_comb begin
    state_d = state_q;
    fault_d = fault_q || fault_set;
    case (state_q)
      ST_IDLE, ST_HALT: if (start && !halt_req && !fault_q) state_d = ST_RUN;
      ST_RUN:           if (halt_req || fault_set) state_d = ST_HALT;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redir_valid) fetch_pc_d = redir_pc;
    else if (issue)  fetch_pc_d = fetch_pc_q + 32'd4;
  end

  // Shift-style FIFO: ent0 is always the head.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (redir_valid) begin
      count_d = 2'd0;
    end else begin
      case ({issue, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_d = new_ent;
          else                 ent1_d = new_ent;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = new_ent;
          end else begin
            ent0_d = ent1_q;
            ent1_d = new_ent;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      ent0_q     <= '0;
      ent1_q     <= '0;
      count_q    <= 2'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      count_q    <= count_d;
      fault_q    <= fault_d;
    end
  end

  assign imem_ce      = issue;
  assign imem_read_en = issue;
  assign imem_pc      = fetch_pc_q;
  assign out_valid    = (count_q != 2'd0);
  assign out_pc       = out_valid ? ent0_q.pc : 32'd0;
  assign out_instr    = out_valid ? ent0_q.instr : 32'd0;
  assign busy         = (state_q == ST_RUN) || out_valid;
  assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table, async-reset and bounds sequences, then random traffic vs a queue model.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          DEPTH_WORDS = 1024;
  localparam logic        T = 1'b1;
  localparam logic        F = 1'b0;

  logic        clk = 1'b0;
  logic        rst, start, halt_req, redir_valid, out_ready;
  logic [31:0] redir_pc;
  logic        imem_ce, imem_read_en, out_valid, busy, fault;
  logic [31:0] imem_pc, imem_instr, out_instr, out_pc;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return 32'hA500_0000 | {22'h0, pc[11:2]};
  endfunction

  assign imem_instr = imem_ce ? word_of(imem_pc) : 32'hDEAD_BEEF;

  fetch_controller #(.RESET_PC(RESET_PC), .DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .imem_ce(imem_ce), .imem_read_en(imem_read_en), .imem_pc(imem_pc),
    .imem_instr(imem_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic s, h, r; logic [31:0] rpc; logic rdy;
    logic ce; logic [31:0] ipc; logic v; logic [31:0] opc; logic bsy; logic flt;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic h, input logic r, input logic [31:0] rpc,
                              input logic rdy, input logic ce, input logic [31:0] ipc, input logic v,
                              input logic [31:0] opc, input logic bsy, input logic flt);
    vec_t x;
    x.s = s; x.h = h; x.r = r; x.rpc = rpc; x.rdy = rdy;
    x.ce = ce; x.ipc = ipc; x.v = v; x.opc = opc; x.bsy = bsy; x.flt = flt;
    return x;
  endfunction

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  vec_t  tbl[24];
  ent_t  mq[$];
  ent_t  e;
  int    mode;        // 0 idle, 1 run, 2 halt
  logic [31:0] mpc;
  logic  mflt;
  logic  pop_m, would_m, bad_m, issue_m;
  int    r;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0; out_ready = 1'b0;

    //            s h r rpc          rdy ce ipc          v  opc          bsy flt
    tbl[0]  = mk(T,F,F,32'h0,       F,  F, 32'h0,       F, 32'h0,       F, F);
    tbl[1]  = mk(F,F,F,32'h0,       F,  T, 32'h0,       F, 32'h0,       T, F);
    tbl[2]  = mk(F,F,F,32'h0,       F,  T, 32'h4,       T, 32'h0,       T, F);
    tbl[3]  = mk(F,F,F,32'h0,       F,  F, 32'h8,       T, 32'h0,       T, F);
    tbl[4]  = mk(F,F,F,32'h0,       F,  F, 32'h8,       T, 32'h0,       T, F);
    tbl[5]  = mk(F,F,F,32'h0,       F,  F, 32'h8,       T, 32'h0,       T, F);
    tbl[6]  = mk(F,F,F,32'h0,       T,  T, 32'h8,       T, 32'h0,       T, F);
    tbl[7]  = mk(F,F,F,32'h0,       T,  T, 32'hC,       T, 32'h4,       T, F);
    tbl[8]  = mk(F,F,F,32'h0,       T,  T, 32'h10,      T, 32'h8,       T, F);
    tbl[9]  = mk(F,F,T,32'h100,     T,  F, 32'h14,      T, 32'hC,       T, F);
    tbl[10] = mk(F,F,F,32'h0,       T,  T, 32'h100,     F, 32'h0,       T, F);
    tbl[11] = mk(F,F,F,32'h0,       T,  T, 32'h104,     T, 32'h100,     T, F);
    tbl[12] = mk(F,F,F,32'h0,       T,  T, 32'h108,     T, 32'h104,     T, F);
    tbl[13] = mk(F,F,F,32'h0,       F,  T, 32'h10C,     T, 32'h108,     T, F);
    tbl[14] = mk(F,T,F,32'h0,       F,  F, 32'h110,     T, 32'h108,     T, F);
    tbl[15] = mk(F,F,F,32'h0,       T,  F, 32'h110,     T, 32'h108,     T, F);
    tbl[16] = mk(F,F,F,32'h0,       T,  F, 32'h110,     T, 32'h10C,     T, F);
    tbl[17] = mk(F,F,F,32'h0,       T,  F, 32'h110,     F, 32'h0,       F, F);
    tbl[18] = mk(T,F,F,32'h0,       T,  F, 32'h110,     F, 32'h0,       F, F);
    tbl[19] = mk(F,F,F,32'h0,       T,  T, 32'h110,     F, 32'h0,       T, F);
    tbl[20] = mk(F,F,F,32'h0,       T,  T, 32'h114,     T, 32'h110,     T, F);
    tbl[21] = mk(F,F,T,32'h102,     T,  F, 32'h118,     T, 32'h114,     T, F);
`ifdef FETCH_BOUNDS_CHECK_EN
    tbl[22] = mk(F,F,F,32'h0,       T,  F, 32'h102,     F, 32'h0,       T, F);
    tbl[23] = mk(F,F,F,32'h0,       T,  F, 32'h102,     F, 32'h0,       F, T);
`else
    tbl[22] = mk(F,F,F,32'h0,       T,  T, 32'h102,     F, 32'h0,       T, F);
    tbl[23] = mk(F,F,F,32'h0,       T,  T, 32'h106,     T, 32'h102,     T, F);
`endif

    // Reset values
    @(posedge clk); #2;
    chk1("rst_ce", imem_ce, 1'b0);
    chk1("rst_read_en", imem_read_en, 1'b0);
    chk("rst_imem_pc", imem_pc, RESET_PC);
    chk1("rst_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_fault", fault, 1'b0);
    rst = 1'b0;

    // Directed table
    for (int k = 0; k < 24; k++) begin
      start = tbl[k].s; halt_req = tbl[k].h; redir_valid = tbl[k].r;
      redir_pc = tbl[k].rpc; out_ready = tbl[k].rdy;
      @(negedge clk);
      chk1($sformatf("r%0d_ce", k), imem_ce, tbl[k].ce);
      chk1($sformatf("r%0d_read_en", k), imem_read_en, tbl[k].ce);
      chk($sformatf("r%0d_imem_pc", k), imem_pc, tbl[k].ipc);
      chk1($sformatf("r%0d_valid", k), out_valid, tbl[k].v);
      if (tbl[k].v) begin
        chk($sformatf("r%0d_out_pc", k), out_pc, tbl[k].opc);
        chk($sformatf("r%0d_out_instr", k), out_instr, word_of(tbl[k].opc));
      end
      chk1($sformatf("r%0d_busy", k), busy, tbl[k].bsy);
      chk1($sformatf("r%0d_fault", k), fault, tbl[k].flt);
      @(posedge clk); #1;
    end
    start = 1'b0; halt_req = 1'b0; redir_valid = 1'b0;

    // Asynchronous reset mid-stream
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chk1("arst_ce", imem_ce, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_imem_pc", imem_pc, RESET_PC);
    chk("arst_out_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("arst_restart_ce", imem_ce, 1'b1);
    chk("arst_restart_pc", imem_pc, RESET_PC);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("arst_first_valid", out_valid, 1'b1);
    chk("arst_first_out_pc", out_pc, RESET_PC);

`ifdef FETCH_BOUNDS_CHECK_EN
    // Redirect beyond the memory end
    do_reset();
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; redir_valid = 1'b1; redir_pc = 32'(DEPTH_WORDS * 4);
    @(posedge clk); #1;
    redir_valid = 1'b0;
    @(negedge clk);
    chk1("oob_no_issue", imem_ce, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk1("oob_fault", fault, 1'b1);
    chk1("oob_busy", busy, 1'b0);
    chk1("oob_valid", out_valid, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk1("oob_start_ignored_ce", imem_ce, 1'b0);
    chk1("oob_start_ignored_busy", busy, 1'b0);
    @(posedge clk); #1;
`endif

    // Random traffic against the queue model
    do_reset();
    mq.delete(); mode = 0; mpc = RESET_PC; mflt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) begin
        start = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
        do_reset();
        mq.delete(); mode = 0; mpc = RESET_PC; mflt = 1'b0;
      end
      start       = ($urandom_range(0, 15) == 0);
      halt_req    = ($urandom_range(0, 31) == 0);
      redir_valid = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      if (r == 0)      redir_pc = 32'(DEPTH_WORDS * 4) + 32'($urandom_range(0, 3)) * 32'd4;
      else if (r == 1) redir_pc = 32'($urandom_range(0, 1023)) * 32'd4 + 32'd2;
      else if (r == 2) redir_pc = 32'hFFFF_FFF8;
      else             redir_pc = 32'($urandom_range(0, 1023)) * 32'd4;

      @(negedge clk);
      pop_m   = (mq.size() > 0) && out_ready && !redir_valid;
      would_m = (mode == 1) && !redir_valid && ((mq.size() < 2) || pop_m);
`ifdef FETCH_BOUNDS_CHECK_EN
      bad_m   = (mpc % 4 != 0) || (mpc >= 32'(DEPTH_WORDS * 4));
`else
      bad_m   = 1'b0;
`endif
      issue_m = would_m && !bad_m;
      chk1("rnd_ce", imem_ce, issue_m);
      chk1("rnd_read_en", imem_read_en, issue_m);
      chk("rnd_imem_pc", imem_pc, mpc);
      chk1("rnd_valid", out_valid, mq.size() > 0);
      if (mq.size() > 0) begin
        chk("rnd_out_pc", out_pc, mq[0].pc);
        chk("rnd_out_instr", out_instr, mq[0].instr);
      end
      chk1("rnd_busy", busy, (mode == 1) || (mq.size() > 0));
      chk1("rnd_fault", fault, mflt);

      @(posedge clk);
      if (redir_valid) begin
        mq.delete();
        mpc = redir_pc;
      end else begin
        if (pop_m) void'(mq.pop_front());
        if (issue_m) begin
          e.pc = mpc; e.instr = word_of(mpc);
          mq.push_back(e);
          mpc = mpc + 32'd4;
        end
      end
      if (would_m && bad_m) begin
        mflt = 1'b1; mode = 2;
      end else if (halt_req) begin
        if (mode == 1) mode = 2;
      end else if (start && !mflt && mode != 1) begin
        mode = 1;
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
